// File: rtl/vme_irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : vme_irq_ctrl
// Description : Parametrised VME interrupter. It latches up to NUM_SRC board
//               interrupt sources, each with a run-time level (1-7) and an
//               8-bit vector. It drives the IRQ7..IRQ1 lines and answers IACK
//               daisy-chain cycles. IACK cycles that this board does not own
//               are passed down the chain on iackout.
// Options     : VME_IRQ_RORA_EN - release-on-register-access. When this
//               macro is defined, an IACK win leaves the source pending until
//               software clears it.
// Revision    : 1.0 - initial release
// ============================================================================
module vme_irq_ctrl #(
  parameter int NUM_SRC = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NUM_SRC-1:0]     src_req,
  input  logic [NUM_SRC-1:0]     src_clr,
  input  logic [3*NUM_SRC-1:0]   src_level,
  input  logic [8*NUM_SRC-1:0]   src_vector,
  input  logic                   iack,
  input  logic [2:0]             vec_addr,
  output logic                   iackout,
  output logic                   dtack,
  output logic [7:1]             irq_n,
  output logic [7:0]             vector,
  output logic [NUM_SRC-1:0]     pending,
  output logic [NUM_SRC-1:0]     overrun
);

  localparam logic [7:0] c_vec_idle = 8'hff;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ARB  = 3'd1,
    ST_ACK  = 3'd2,
    ST_PASS = 3'd3,
    ST_REL  = 3'd4
  } state_t;

  state_t               r_state;
  state_t               w_next_state;
  logic                 r_iack;
  logic [2:0]           r_lvl;
  logic [NUM_SRC-1:0]   r_pending;
  logic [NUM_SRC-1:0]   r_overrun;
  logic [7:1]           r_irq_n;
  logic                 r_dtack;
  logic                 r_iackout;
  logic [7:0]           r_vector;

  logic [NUM_SRC-1:0]   w_src_en;
  logic [NUM_SRC-1:0]   w_set;
  logic [NUM_SRC-1:0]   w_ovr_set;
  logic [NUM_SRC-1:0]   w_win_oh;
  logic [NUM_SRC-1:0]   w_ack_clr;
  logic [NUM_SRC-1:0]   w_roak_clr;
  logic                 w_hit;
  logic [7:0]           w_win_vec;
  logic [7:1]           w_irq_act;
  logic                 w_lvl_load;
  logic                 w_dtack_nxt;
  logic                 w_iackout_nxt;
  logic [7:0]           w_vector_nxt;

  // A source is enabled whenever its level is non-zero.
  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
    assign w_src_en[gi] = (src_level[3*gi +: 3] != 3'd0);
  end

  assign w_set     = src_req & w_src_en;
  assign w_ovr_set = w_set & r_pending;

`ifdef VME_IRQ_RORA_EN
  // Release on register access: a won IACK leaves the request pending.
  assign w_roak_clr = '0;
`else
  // Release on acknowledge: the IACK winner's pending bit is cleared.
  assign w_roak_clr = w_ack_clr;
`endif

  // The IACK input is registered once. All FSM timing is measured from it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_iack <= 1'b0;
    else          r_iack <= iack;
  end

  // The pending and overrun latches. A set wins over a clear on the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pending <= '0;
      r_overrun <= '0;
    end else begin
      r_pending <= w_set | (r_pending & ~(src_clr | w_roak_clr));
      r_overrun <= w_ovr_set | (r_overrun & ~src_clr);
    end
  end

  // A level is active when any pending source is currently assigned to it.
  always_comb begin
    w_irq_act = '0;
    for (int l = 1; l < 8; l++) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (r_pending[i] && (src_level[3*i +: 3] == 3'(l))) w_irq_act[l] = 1'b1;
      end
    end
  end

  // The IRQ lines are registered and active-low.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_irq_n <= 7'h7f;
    else          r_irq_n <= ~w_irq_act;
  end

  // Priority arbitration: the lowest-index pending source at the captured level wins.
  always_comb begin
    w_hit     = 1'b0;
    w_win_oh  = '0;
    w_win_vec = c_vec_idle;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (r_pending[i] && (r_lvl != 3'd0) && (src_level[3*i +: 3] == r_lvl)) begin
        w_hit       = 1'b1;
        w_win_oh    = '0;
        w_win_oh[i] = 1'b1;
        w_win_vec   = src_vector[8*i +: 8];
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_next_state;
  end

  // FSM next-state logic and the next values of the registered outputs.
  always_comb begin
    w_next_state  = r_state;
    w_lvl_load    = 1'b0;
    w_ack_clr     = '0;
    w_dtack_nxt   = r_dtack;
    w_iackout_nxt = r_iackout;
    w_vector_nxt  = r_vector;
    case (r_state)
      ST_IDLE: begin
        if (r_iack) begin
          w_next_state = ST_ARB;
          w_lvl_load   = 1'b1;
        end
      end
      ST_ARB: begin
        if (!r_iack) begin
          w_next_state = ST_IDLE;
        end else if (w_hit) begin
          w_next_state = ST_ACK;
          w_dtack_nxt  = 1'b1;
          w_vector_nxt = w_win_vec;
          w_ack_clr    = w_win_oh;
        end else begin
          w_next_state  = ST_PASS;
          w_iackout_nxt = 1'b1;
        end
      end
      ST_ACK, ST_PASS: begin
        if (!r_iack) begin
          w_next_state  = ST_REL;
          w_dtack_nxt   = 1'b0;
          w_iackout_nxt = 1'b0;
          w_vector_nxt  = c_vec_idle;
        end
      end
      ST_REL: begin
        // One dead cycle guarantees that the bus sees the release.
        w_next_state = ST_IDLE;
      end
      default: begin
        w_next_state  = ST_IDLE;
        w_dtack_nxt   = 1'b0;
        w_iackout_nxt = 1'b0;
        w_vector_nxt  = c_vec_idle;
      end
    endcase
  end

  // The captured IACK level and the registered bus responses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_lvl     <= 3'd0;
      r_dtack   <= 1'b0;
      r_iackout <= 1'b0;
      r_vector  <= c_vec_idle;
    end else begin
      if (w_lvl_load) r_lvl <= vec_addr;
      r_dtack   <= w_dtack_nxt;
      r_iackout <= w_iackout_nxt;
      r_vector  <= w_vector_nxt;
    end
  end

  assign iackout = r_iackout;
  assign dtack   = r_dtack;
  assign irq_n   = r_irq_n;
  assign vector  = r_vector;
  assign pending = r_pending;
  assign overrun = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_vme_irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_vme_irq_ctrl
// Description : Directed self-checking bench for vme_irq_ctrl. The expected
//               IACK responses are queued when each cycle is started and are
//               compared when the DUT responds.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vme_irq_ctrl;

  localparam int NUM_SRC = 4;

  logic                 clk;
  logic                 reset_n;
  logic [NUM_SRC-1:0]   src_req;
  logic [NUM_SRC-1:0]   src_clr;
  logic [3*NUM_SRC-1:0] src_level;
  logic [8*NUM_SRC-1:0] src_vector;
  logic                 iack;
  logic [2:0]           vec_addr;
  logic                 iackout;
  logic                 dtack;
  logic [7:1]           irq_n;
  logic [7:0]           vector;
  logic [NUM_SRC-1:0]   pending;
  logic [NUM_SRC-1:0]   overrun;

  typedef struct packed {
    logic       dt;
    logic       io;
    logic [7:0] vec;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  vme_irq_ctrl #(.NUM_SRC(NUM_SRC)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .src_req    (src_req),
    .src_clr    (src_clr),
    .src_level  (src_level),
    .src_vector (src_vector),
    .iack       (iack),
    .vec_addr   (vec_addr),
    .iackout    (iackout),
    .dtack      (dtack),
    .irq_n      (irq_n),
    .vector     (vector),
    .pending    (pending),
    .overrun    (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_req(input logic [NUM_SRC-1:0] r, input logic [NUM_SRC-1:0] c);
    src_req = r;
    src_clr = c;
    tick;
    src_req = '0;
    src_clr = '0;
  endtask

  // Runs one full IACK cycle. The expected response is queued up front and
  // compared when the DUT asserts dtack or iackout.
  task automatic do_iack(input logic [2:0] addr, input logic e_dt, input logic e_io,
                         input logic [7:0] e_vec, input bit scramble);
    exp_t e;
    int   lat;
    bit   got;
    logic [8*NUM_SRC-1:0] saved;
    sb.push_back('{dt: e_dt, io: e_io, vec: e_vec});
    iack     = 1'b1;
    vec_addr = addr;
    lat = 0;
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      tick;
      lat++;
      if (dtack || iackout) got = 1'b1;
    end
    e = sb.pop_front();
    chk("iack_latency", 32'(lat), 32'd3);
    chk("iack_dtack", {31'd0, dtack}, {31'd0, e.dt});
    chk("iack_iackout", {31'd0, iackout}, {31'd0, e.io});
    chk("iack_vector", {24'd0, vector}, {24'd0, e.vec});
    if (scramble) begin
      saved = src_vector;
      src_vector = ~src_vector;
      tick;
      chk("vector_hold", {24'd0, vector}, {24'd0, e.vec});
      src_vector = saved;
    end
    iack = 1'b0;
    tick;
    chk("release_hold", {31'd0, dtack | iackout}, 32'd1);
    tick;
    chk("release_dtack", {31'd0, dtack}, 32'd0);
    chk("release_iackout", {31'd0, iackout}, 32'd0);
    chk("release_vector", {24'd0, vector}, 32'hff);
    tick;
  endtask

  initial begin
    bit seen;
    reset_n    = 1'b0;
    src_req    = '0;
    src_clr    = '0;
    src_level  = '0;
    src_vector = '0;
    iack       = 1'b0;
    vec_addr   = 3'd0;
    repeat (3) tick;
    reset_n = 1'b1;
    tick;

    // Reset values
    chk("rst_irq_n", {25'd0, irq_n}, 32'h7f);
    chk("rst_vector", {24'd0, vector}, 32'hff);
    chk("rst_dtack", {31'd0, dtack}, 32'd0);
    chk("rst_iackout", {31'd0, iackout}, 32'd0);
    chk("rst_pending", {28'd0, pending}, 32'd0);
    chk("rst_overrun", {28'd0, overrun}, 32'd0);

    // Single source at level 6
    src_level[2:0]  = 3'd6;
    src_vector[7:0] = 8'hfe;
    pulse_req(4'b0001, 4'b0000);
    chk("single_pending", {28'd0, pending}, 32'h1);
    chk("single_irq_1clk", {25'd0, irq_n}, 32'h7f);
    tick;
    chk("single_irq_2clk", {25'd0, irq_n}, 32'h5f);
    do_iack(3'd6, 1'b1, 1'b0, 8'hfe, 1'b0);
    chk("single_pending_clr", {28'd0, pending}, 32'h0);
    chk("single_irq_rel", {25'd0, irq_n}, 32'h7f);

    // Priority between sources 1 and 3 at level 3
    src_level[5:3]    = 3'd3;
    src_level[11:9]   = 3'd3;
    src_vector[15:8]  = 8'h41;
    src_vector[31:24] = 8'h43;
    pulse_req(4'b1010, 4'b0000);
    tick;
    chk("prio_irq", {25'd0, irq_n}, 32'h7b);
    do_iack(3'd3, 1'b1, 1'b0, 8'h41, 1'b0);
    chk("prio_irq_still", {25'd0, irq_n}, 32'h7b);
    chk("prio_pending", {28'd0, pending}, 32'h8);
    do_iack(3'd3, 1'b1, 1'b0, 8'h43, 1'b0);
    chk("prio_irq_rel", {25'd0, irq_n}, 32'h7f);
    chk("prio_pending_clr", {28'd0, pending}, 32'h0);

    // Pass-through: source 2 at level 5, IACK for level 2
    src_level[8:6]    = 3'd5;
    src_vector[23:16] = 8'h55;
    pulse_req(4'b0100, 4'b0000);
    tick;
    do_iack(3'd2, 1'b0, 1'b1, 8'hff, 1'b0);
    chk("pass_pending", {28'd0, pending}, 32'h4);
    chk("pass_irq", {25'd0, irq_n}, 32'h6f);

    // Overrun and software clear
    pulse_req(4'b0000, 4'b0100);
    chk("clr_pending", {28'd0, pending}, 32'h0);
    pulse_req(4'b0100, 4'b0000);
    chk("ovr_first", {28'd0, overrun}, 32'h0);
    pulse_req(4'b0100, 4'b0000);
    chk("ovr_second", {28'd0, overrun}, 32'h4);
    pulse_req(4'b0000, 4'b0100);
    chk("ovr_clr_pending", {28'd0, pending}, 32'h0);
    chk("ovr_clr_overrun", {28'd0, overrun}, 32'h0);
    pulse_req(4'b0100, 4'b0100);
    chk("set_wins_pending", {28'd0, pending}, 32'h4);
    pulse_req(4'b0100, 4'b0100);
    chk("set_wins_overrun", {28'd0, overrun}, 32'h4);

    // Abort: iack dropped while arbitrating
    iack     = 1'b1;
    vec_addr = 3'd5;
    tick;
    iack = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick;
      if (dtack || iackout) seen = 1'b1;
    end
    chk("abort_no_resp", {31'd0, seen}, 32'd0);
    chk("abort_pending", {28'd0, pending}, 32'h4);

    // Normal win after the abort. Vector changes after arbitration are ignored.
    do_iack(3'd5, 1'b1, 1'b0, 8'h55, 1'b1);
    chk("win5_pending", {28'd0, pending}, 32'h0);
    chk("win5_overrun_kept", {28'd0, overrun}, 32'h4);
    pulse_req(4'b0000, 4'b0100);
    chk("final_overrun_clr", {28'd0, overrun}, 32'h0);

    // Asynchronous reset drops dtack mid-cycle.
    pulse_req(4'b0001, 4'b0000);
    tick;
    iack     = 1'b1;
    vec_addr = 3'd6;
    repeat (3) tick;
    chk("async_pre_dtack", {31'd0, dtack}, 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_dtack", {31'd0, dtack}, 32'd0);
    chk("async_vector", {24'd0, vector}, 32'hff);
    chk("async_pending", {28'd0, pending}, 32'h0);
    iack = 1'b0;
    tick;
    reset_n = 1'b1;
    tick;
    chk("async_irq", {25'd0, irq_n}, 32'h7f);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
